ioctl_upload_bridge: RTL and testbench

- Core-side responder for the HPS ioctl upload (read-back) direction; the counterpart of the download path that loads BIOS and font images.
- Serves byte reads from hps_io out of a shared core RAM, such as NVRAM or a save area, through a request/ack memory port.
- Raises and retires upload requests on behalf of the core.
- Sits in emu between hps_io and system; the CPU shares the memory arbiter with this block.

---
 rtl/ioctl_pkg.sv | 18 +
 rtl/upload_req_ctl.sv | 31 +++
 rtl/ioctl_upload_bridge.sv | 112 +++++++++++
 tb/tb_ioctl_upload_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_pkg.sv
// ioctl_pkg: shared types and defaults for the ioctl upload bridge. Rev 1.0
`default_nettype none

package ioctl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  localparam logic [7:0] DEF_INDEX  = 8'd2;
  localparam logic [7:0] DEF_FILL   = 8'hFF;
  localparam int         DEF_ADDR_W = 17;

  typedef logic [DEF_ADDR_W-1:0] ioctl_addr_t;
endpackage

`default_nettype wire

// File: rtl/upload_req_ctl.sv
// upload_req_ctl: save request to ioctl_upload_req set/clear/re-arm logic. Rev 1.0
`default_nettype none

module upload_req_ctl (
  input  logic clk,
  input  logic reset,
  input  logic save_req,
  input  logic upload,
  input  logic sel,
  output logic upload_req
);
  logic pending;

  // A save asked for during our own session is parked until the session ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upload_req <= 1'b0;
      pending    <= 1'b0;
    end else if (sel) begin
      upload_req <= 1'b0;
      if (save_req) pending <= 1'b1;
    end else if (save_req) begin
      upload_req <= 1'b1;
    end else if (pending && !upload) begin
      upload_req <= 1'b1;
      pending    <= 1'b0;
    end
  end
endmodule

`default_nettype wire

// File: rtl/ioctl_upload_bridge.sv
// ioctl_upload_bridge: serves hps_io upload reads from core RAM via a req/ack port.
// Optional checksum output enabled by IOCTL_UPLOAD_CHECKSUM_EN. Rev 1.0
`default_nettype none

module ioctl_upload_bridge
  import ioctl_pkg::*;
#(
  parameter int          ADDR_W = DEF_ADDR_W,
  parameter int unsigned SIZE   = 32'h10000,
  parameter logic [7:0]  INDEX  = DEF_INDEX,
  parameter logic [7:0]  FILL   = DEF_FILL
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic              save_req,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err_overrun
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
  ,
  output logic [15:0]       csum
`endif
);
  fetch_state_t state, state_nx;
  logic sel, sel_q, sel_rise, in_range, load;
  logic [7:0] load_byte;

  assign sel      = ioctl_upload && (ioctl_index == INDEX);
  assign sel_rise = sel && !sel_q;
  assign in_range = 64'(ioctl_addr) < 64'(SIZE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mem_rd     = 1'b0;
    ioctl_wait = 1'b0;
    load       = 1'b0;
    load_byte  = mem_rdata;
    case (state)
      IDLE: begin
        if (ioctl_rd && sel) begin
          if (in_range) begin
            state_nx = FETCH;
          end else begin
            load      = 1'b1;
            load_byte = FILL;
          end
        end
      end
      FETCH: begin
        mem_rd     = 1'b1;
        ioctl_wait = 1'b1;
        // Losing the session abandons the fetch; any later ack lands in IDLE.
        if (!sel)         state_nx = IDLE;
        else if (mem_ack) begin
          state_nx = DONE;
          load     = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sel_q       <= 1'b0;
      ioctl_din   <= 8'h00;
      mem_addr    <= '0;
      err_overrun <= 1'b0;
    end else begin
      sel_q <= sel;
      if (state == IDLE && ioctl_rd && sel && in_range) mem_addr <= ioctl_addr;
      if (load) ioctl_din <= load_byte;
      if (ioctl_rd && busy)  err_overrun <= 1'b1;
      else if (sel_rise)     err_overrun <= 1'b0;
    end
  end

`ifdef IOCTL_UPLOAD_CHECKSUM_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) csum <= 16'h0000;
    else       csum <= (sel_rise ? 16'h0000 : csum) + (load ? {8'h00, load_byte} : 16'h0000);
  end
`endif

  upload_req_ctl u_req_ctl (
    .clk        (clk_sys),
    .reset      (reset),
    .save_req   (save_req),
    .upload     (ioctl_upload),
    .sel        (sel),
    .upload_req (ioctl_upload_req)
  );
endmodule

`default_nettype wire

// File: tb/tb_ioctl_upload_bridge.sv
// tb_ioctl_upload_bridge: vector table, randomized reads vs. transaction model, corner sequences.
`default_nettype none

module tb_ioctl_upload_bridge;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic        save_req;
  logic        mem_rd;
  logic [16:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        err_overrun;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
  logic [15:0] csum;
`endif

  logic [7:0] ram [0:131071];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;
  assign mem_rdata = ram[mem_addr];

  ioctl_upload_bridge dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .ioctl_wait       (ioctl_wait),
    .ioctl_upload_req (ioctl_upload_req),
    .save_req         (save_req),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .busy             (busy),
    .err_overrun      (err_overrun)
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    ,
    .csum             (csum)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One strobe; ack is given on fetch cycle d+1. Returns observed wait cycles and RAM activity.
  task automatic do_read(input logic [16:0] a, input logic [7:0] idx, input int d,
                         output int waits, output bit rd_seen, output logic [16:0] seen_addr);
    int cyc;
    waits = 0; cyc = 0; seen_addr = '0;
    ioctl_index = idx; ioctl_addr = a; ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0; ioctl_index = 8'd2;
    rd_seen = mem_rd;
    while (ioctl_wait && cyc < 20) begin
      waits++;
      rd_seen |= mem_rd;
      if (mem_rd) seen_addr = mem_addr;
      mem_ack = (waits == d + 1);
      step();
      cyc++;
    end
    mem_ack = 1'b0;
    if (cyc >= 20) chk("fetch_timeout", 32'(cyc), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [16:0] addr;
    logic [7:0]  idx;
    int          delay;
    logic [7:0]  exp_din;
    int          exp_waits;
    bit          exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          w;
    bit          rs;
    logic [16:0] sa;
    logic [7:0]  m_din;
    logic [15:0] m_csum;
    logic [16:0] a, a2;

    vecs[0] = '{"inrange_10",   17'h00010, 8'd2, 3, 8'hA5, 4, 1'b1};
    vecs[1] = '{"oor_10000",    17'h10000, 8'd2, 0, 8'hFF, 0, 1'b0};
    vecs[2] = '{"wrong_index",  17'h00020, 8'd1, 0, 8'hFF, 0, 1'b0};
    vecs[3] = '{"inrange_ffff", 17'h0FFFF, 8'd2, 0, 8'h3C, 1, 1'b1};
    vecs[4] = '{"oor_1ffff",    17'h1FFFF, 8'd2, 0, 8'hFF, 0, 1'b0};
    vecs[5] = '{"inrange_0",    17'h00000, 8'd2, 5, 8'h81, 6, 1'b1};
    vecs[6] = '{"wrong_idx_oor",17'h10000, 8'd3, 0, 8'h81, 0, 1'b0};

    for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);
    ram[17'h00010] = 8'hA5;
    ram[17'h0FFFF] = 8'h3C;
    ram[17'h00000] = 8'h81;

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd2; ioctl_rd = 1'b0;
    ioctl_addr = '0; save_req = 1'b0; mem_ack = 1'b0;
    step(); step();
    chk("reset_din", 32'(ioctl_din), 32'h0);
    chk("reset_ctrl", {27'd0, ioctl_wait, ioctl_upload_req, mem_rd, busy, err_overrun}, 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    ioctl_upload = 1'b1;
    step(); step();

    for (int i = 0; i < 7; i++) begin
      do_read(vecs[i].addr, vecs[i].idx, vecs[i].delay, w, rs, sa);
      chk({vecs[i].name, "_din"}, 32'(ioctl_din), 32'(vecs[i].exp_din));
      chk({vecs[i].name, "_waits"}, 32'(w), 32'(vecs[i].exp_waits));
      chk({vecs[i].name, "_memrd"}, 32'(rs), 32'(vecs[i].exp_rd));
      if (vecs[i].exp_rd) chk({vecs[i].name, "_addr"}, 32'(sa), 32'(vecs[i].addr));
      step();
      chk({vecs[i].name, "_idle"}, {30'd0, busy, err_overrun}, 32'h0);
    end

    // Randomized reads against a transaction-level model.
    ioctl_upload = 1'b0; step(); ioctl_upload = 1'b1; step();
    m_din = 8'h81; m_csum = 16'h0;
    for (int n = 0; n < 40; n++) begin
      int       d;
      bit       s, inr;
      logic [7:0] idx;
      inr = ($urandom_range(3, 0) != 0);
      a   = inr ? 17'($urandom_range(32'hFFFF, 0)) : 17'(32'h10000 + $urandom_range(32'hFFFF, 0));
      s   = ($urandom_range(9, 0) != 0);
      idx = s ? 8'd2 : 8'd7;
      d   = int'($urandom_range(5, 0));
      do_read(a, idx, d, w, rs, sa);
      if (s) begin
        m_din  = inr ? ram[a] : 8'hFF;
        m_csum = m_csum + 16'(m_din);
      end else begin
        m_csum = 16'h0;
      end
      chk("rand_din", 32'(ioctl_din), 32'(m_din));
      chk("rand_waits", 32'(w), (s && inr) ? 32'(d + 1) : 32'd0);
      chk("rand_memrd", 32'(rs), 32'(s && inr));
      step();
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
      chk("rand_csum", 32'(csum), 32'(m_csum));
`endif
    end

    // Overrun: second strobe during FETCH is ignored, first fetch completes.
    a = 17'h01234; a2 = 17'h04321;
    ioctl_addr = a; ioctl_rd = 1'b1; step();
    ioctl_addr = a2;  step();
    ioctl_rd = 1'b0; step();
    chk("ovr_err", 32'(err_overrun), 32'd1);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("ovr_din", 32'(ioctl_din), 32'(ram[a]));
    chk("ovr_addr", 32'(mem_addr), 32'(a));
    rs = 1'b0;
    for (int k = 0; k < 4; k++) begin step(); rs |= mem_rd; end
    chk("ovr_no_second_rd", 32'(rs), 32'd0);
    chk("ovr_sticky", 32'(err_overrun), 32'd1);
    ioctl_upload = 1'b0; step(); ioctl_upload = 1'b1; step();
    chk("ovr_clear_on_sel_rise", 32'(err_overrun), 32'd0);
    m_din = ram[a];

    // Abort: session drops mid-fetch, late ack has no effect.
    ioctl_addr = 17'h00100; ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0;
    chk("abort_in_fetch", {30'd0, mem_rd, ioctl_wait}, 32'h3);
    ioctl_upload = 1'b0; step();
    chk("abort_drop", {29'd0, mem_rd, ioctl_wait, busy}, 32'h0);
    mem_ack = 1'b1; step(); mem_ack = 1'b0; step();
    chk("abort_din_kept", 32'(ioctl_din), 32'(m_din));

    // Upload request set / hold / clear / re-arm.
    save_req = 1'b1; step(); save_req = 1'b0;
    chk("req_set", 32'(ioctl_upload_req), 32'd1);
    save_req = 1'b1; step(); save_req = 1'b0; step();
    chk("req_hold", 32'(ioctl_upload_req), 32'd1);
    ioctl_upload = 1'b1; ioctl_index = 8'd1; step();
    chk("req_other_index", 32'(ioctl_upload_req), 32'd1);
    ioctl_index = 8'd2; step();
    chk("req_clear", 32'(ioctl_upload_req), 32'd0);
    save_req = 1'b1; step(); save_req = 1'b0; step();
    chk("req_parked", 32'(ioctl_upload_req), 32'd0);
    ioctl_upload = 1'b0; step();
    chk("req_rearm", 32'(ioctl_upload_req), 32'd1);
    ioctl_upload = 1'b1; step();
    chk("req_rearm_clear", 32'(ioctl_upload_req), 32'd0);

`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    ioctl_upload = 1'b0; step(); ioctl_upload = 1'b1; step();
    ram[17'h00200] = 8'h01; ram[17'h00201] = 8'h02;
    do_read(17'h00200, 8'd2, 1, w, rs, sa); step();
    do_read(17'h00201, 8'd2, 0, w, rs, sa); step();
    do_read(17'h10005, 8'd2, 0, w, rs, sa); step();
    chk("csum_01_02_ff", 32'(csum), 32'h0102);
`endif

    // Asynchronous reset in the middle of a fetch.
    ioctl_addr = 17'h00777; ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0; step();
    chk("rst_pre_fetch", {31'd0, mem_rd}, 32'd1);
    #2 reset = 1'b1; #1;
    chk("rst_async_ctrl", {27'd0, ioctl_wait, ioctl_upload_req, mem_rd, busy, err_overrun}, 32'h0);
    chk("rst_async_din", 32'(ioctl_din), 32'h0);
    chk("rst_async_addr", 32'(mem_addr), 32'h0);
    step(); reset = 1'b0; step();
    chk("rst_after_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
